// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared state, tag type and defaults for the BRAM read arbiter
package bram_arb_pkg;
  localparam int DEF_BRAM_DELAY = 2;
  localparam int DEF_ADDR_INC = 4;
  localparam int TAG_ID_W = 3;
  localparam int TAG_IDX_W = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} arb_state_t;
  typedef struct packed {
    logic                 valid;
    logic [TAG_ID_W-1:0]  id;
    logic [TAG_IDX_W-1:0] index;
    logic                 last;
  } arb_tag_t;
endpackage

// File: rtl/bram_read_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder, searching upward from ptr_i
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[(int'(ptr_i) + i) % N]) idx_o = W'((int'(ptr_i) + i) % N);
    gnt_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: shares one BRAM read port among N_REQ burst requesters, round-robin,
// returning each word tagged with requester id and word index.
module bram_read_arbiter
  import bram_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int LEN_W      = 9,
  parameter int BRAM_DELAY = DEF_BRAM_DELAY,
  parameter int ADDR_INC   = DEF_ADDR_INC
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ-1:0][31:0]          req_addr,
  input  logic [N_REQ-1:0][LEN_W-1:0]     req_len,
  output logic                            rsp_valid,
  output logic [$clog2(N_REQ)-1:0]        rsp_id,
  output logic [LEN_W-1:0]                rsp_index,
  output logic [31:0]                     rsp_data,
  output logic                            rsp_last,
  output logic [N_REQ-1:0]                done,
  output logic                            BRAM_clk,
  output logic [31:0]                     BRAM_addr,
  output logic                            BRAM_en,
  output logic [3:0]                      BRAM_we,
  output logic [31:0]                     BRAM_din,
  output logic                            BRAM_rst,
  input  logic [31:0]                     BRAM_dout
);
  localparam int ID_W = $clog2(N_REQ);
  arb_state_t state_q;
  logic [ID_W-1:0] ptr_q, id_q, g;
  logic [N_REQ-1:0] gnt, done_q;
  logic any, brst_q, en_q;
  logic [31:0] addr_q;
  logic [LEN_W-1:0] k_q, len_q;
  arb_tag_t pipe_q [BRAM_DELAY];
  arb_tag_t in_tag, tail;
  logic tag_unused;

  rr_picker #(.N(N_REQ)) u_picker (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (g),
    .any_o (any)
  );

  // The tag travels alongside each issued address so the beat meets its data at the pipe tail
  assign in_tag = (state_q == ISSUE) ? arb_tag_t'{valid: 1'b1, id: TAG_ID_W'(id_q),
                                                  index: TAG_IDX_W'(k_q), last: k_q == len_q - 1'b1}
                                     : '0;
  assign tail = pipe_q[BRAM_DELAY-1];
  assign tag_unused = ^tail;

  // No grant while BRAM_rst is still high, so req_ready reads 0 throughout reset
  assign req_ready = (state_q == IDLE && !brst_q) ? gnt : '0;
  assign rsp_valid = tail.valid;
  assign rsp_id    = tail.id[ID_W-1:0];
  assign rsp_index = tail.index[LEN_W-1:0];
  assign rsp_last  = tail.last;
  assign rsp_data  = BRAM_dout;
  assign done      = done_q;
  assign BRAM_clk  = clk;
  assign BRAM_addr = addr_q;
  assign BRAM_en   = en_q;
  assign BRAM_we   = '0;
  assign BRAM_din  = '0;
  assign BRAM_rst  = brst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      brst_q  <= 1'b1;
      k_q     <= '0;
      len_q   <= '0;
      done_q  <= '0;
      for (int i = 0; i < BRAM_DELAY; i++) pipe_q[i] <= '0;
    end else begin
      brst_q    <= 1'b0;
      pipe_q[0] <= in_tag;
      for (int i = 1; i < BRAM_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
      done_q <= (tail.valid && tail.last) ? N_REQ'(1) << tail.id : '0;
      case (state_q)
        IDLE: if (any && !brst_q) begin
          ptr_q <= (g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1;
          id_q  <= g;
          if (req_len[g] == '0) done_q <= gnt;
          else begin
            state_q <= ISSUE;
            en_q    <= 1'b1;
            addr_q  <= req_addr[g];
            len_q   <= req_len[g];
            k_q     <= '0;
          end
        end
        ISSUE: if (k_q == len_q - 1'b1) begin
          state_q <= DRAIN;
          en_q    <= 1'b0;
        end else begin
          k_q    <= k_q + 1'b1;
          addr_q <= addr_q + 32'(ADDR_INC);
        end
        DRAIN: if (tail.valid && tail.last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bram_read_arbiter.md
# bram_read_arbiter

Round-robin scheduler that shares one read port of the sample BRAM among `N_REQ` DMA requesters, such as per-voice clip loaders and refresh engines. Each requester posts a burst descriptor (base byte address, word count). The arbiter grants one burst at a time, drives the BRAM port one word per cycle, and returns the read data tagged with requester ID and word index. It sits between the PS-side BRAM controller port and the I2S/player sample buffers.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8)
- `LEN_W`, 9: burst-length / index width
- `BRAM_DELAY`, 2: BRAM read latency in cycles
- `ADDR_INC`, 4: byte address step per word

Ports:
- `clk`  in  1  system clock, also forwarded to the BRAM
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  N_REQ  burst request pending, per requester
- `req_ready`  out  N_REQ  one-hot accept pulse
- `req_addr`  in  N_REQ×32  base byte address, per requester
- `req_len`  in  N_REQ×LEN_W  word count, per requester
- `rsp_valid`  out  1  read data beat valid
- `rsp_id`  out  $clog2(N_REQ)  owner of the beat
- `rsp_index`  out  LEN_W  word index within the burst
- `rsp_data`  out  32  BRAM word
- `rsp_last`  out  1  final beat of the burst
- `done`  out  N_REQ  one-cycle completion pulse, per requester
- `BRAM_clk`  out  1  equals `clk`
- `BRAM_addr`  out  32
- `BRAM_en`  out  1
- `BRAM_we`  out  4  always 0
- `BRAM_din`  out  32  always 0
- `BRAM_rst`  out  1
- `BRAM_dout`  in  32

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - If any `req_valid` is set, the round-robin picker selects winner `g`, searching upward from `ptr` and wrapping.
  - `req_ready[g]` is 1 in that same cycle, combinational from state and requester inputs. The handshake is `req_valid & req_ready`.
  - On handshake: latch `req_addr[g]`, `req_len[g]`, `g`; set `ptr <= (g+1) mod N_REQ`; go to ISSUE.
  - If `req_len == 0`: no ISSUE; `done[g]` pulses next cycle; `ptr` still advances; stay IDLE.
- ISSUE:
  - `BRAM_en = 1`; `BRAM_addr = base + ADDR_INC*k` for k = 0..len-1, one per cycle, modulo 2^32 (wraps silently).
  - A tag shift register of depth `BRAM_DELAY` carries (valid, id, k, k==len-1) alongside each issued address.
  - After k = len-1 go to DRAIN.
- DRAIN: `BRAM_en = 0` for `BRAM_DELAY` cycles, until the tag pipe is empty, then IDLE.
- Responses:
  - `rsp_*` are driven from the pipe tail and `rsp_data = BRAM_dout`.
  - Responses cannot be back-pressured; consumers must accept every beat.
- `done[id]` pulses the cycle after the `rsp_last` beat.
- `req_valid` dropped before grant: the request is withdrawn, not an error. A requester's inputs are ignored while it is not granted.

## Timing
- Reset values: `BRAM_en` 0, `BRAM_addr` 0, `BRAM_we` 0, `BRAM_din` 0, `BRAM_rst` 1; `req_ready`, `rsp_valid`, `rsp_last`, `done` 0; `rsp_id`, `rsp_index` 0; `ptr` 0; state IDLE.
- `BRAM_rst` deasserts on the first clock edge after reset release.
- Handshake at cycle T: first address at T+1, first `rsp_valid` at T+1+BRAM_DELAY, `rsp_last` at T+len+BRAM_DELAY, `done` at T+len+BRAM_DELAY+1.
- Port occupancy per burst is 1+len+BRAM_DELAY cycles; the next grant is possible in the cycle after DRAIN ends.
- Fairness: with all requesters continuously valid, grant order is 0,1,…,N_REQ-1,0,…
- Reset mid-burst: the FSM returns to IDLE and the tag pipe is cleared. No further `rsp_valid` or `done` is produced for the aborted burst.

## Structure
- Package `bram_arb_pkg`: `arb_state_t` enum, `BRAM_DELAY` and `ADDR_INC` defaults, and the tag struct (valid, id, index, last).
- Sub-module `rr_picker`: combinational round-robin priority encoder taking request vector and `ptr`, producing one-hot grant and index.

## Test plan
- Single request: id 2, addr 0x100, len 3, BRAM preloaded with word i = i -> addresses 0x100/0x104/0x108; beats (2,0,0x40),(2,1,0x41),(2,2,0x42 last); `done[2]` one cycle later.
- All four requesters held valid, len 2 each -> grants in order 0,1,2,3,0; every burst occupies 5 cycles; no interleaved beats.
- len 0 from requester 1 -> `req_ready[1]`, then `done[1]` next cycle, zero `rsp_valid`, `BRAM_en` stays 0.
- Address wrap: addr 0xFFFFFFFC, len 2 -> `BRAM_addr` 0xFFFFFFFC then 0x00000000.
- Reset asserted at the second beat of a len-8 burst -> all outputs return to reset values immediately; no `done`; a fresh request after release is served from `ptr` 0.
- Max length 511 -> `rsp_index` runs 0..510, `rsp_last` only on 510.
